// File: rtl/ram_row_streamer.sv
// ram_row_streamer: read-side sequencer for the wide row port of the activation/weight RAM.
// On start it issues a strided run of single-cycle row reads and returns the rows over a
// valid/ready stream. A 2-entry FIFO absorbs the RAM's one-cycle read latency, so reads are
// throttled by a credit check and backpressure never drops a row.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start_i                launch (IDLE only); base_addr_i/stride_i/num_rows_i latched on start
//   abort_i                cancel the transfer and flush (ignored in IDLE)
//   busy_o, done_o         not-IDLE flag; one-cycle completion/abort pulse
//   rd_en_o, rd_addr_o     RAM row-port read request
//   rd_data_i              RAM row data, valid the cycle after rd_en_o
//   row_data_o/valid/last  FIFO head toward the compute array
//   row_ready_i            downstream accept
module ram_row_streamer #(
  parameter int unsigned addrWidth  = 32,
  parameter int unsigned dataSize   = 8,
  parameter int unsigned rowWidth   = 256,
  parameter int unsigned countWidth = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [addrWidth-1:0]  base_addr_i,
  input  logic [addrWidth-1:0]  stride_i,
  input  logic [countWidth-1:0] num_rows_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rd_en_o,
  output logic [addrWidth-1:0]  rd_addr_o,
  input  logic [rowWidth-1:0]   rd_data_i,
  output logic [rowWidth-1:0]   row_data_o,
  output logic                  row_valid_o,
  input  logic                  row_ready_i,
  output logic                  row_last_o
);

  if (rowWidth % dataSize != 0) begin : g_bad_width
    $error("rowWidth must be a whole number of dataSize entries");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic [addrWidth-1:0]  addr_q, addr_d;
  logic [addrWidth-1:0]  stride_q, stride_d;
  logic [countWidth-1:0] num_rows_q, num_rows_d;
  logic [countWidth-1:0] issued_q, issued_d;
  logic [countWidth-1:0] accepted_q, accepted_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  done_q, done_d;

  logic [rowWidth-1:0]   fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic                  pop, issue, last_pop, flush, credit_ok;
  logic [2:0]            occupancy;

  assign row_valid_o = (count_q != 2'd0);
  assign pop         = row_valid_o && row_ready_i;
  // Rows already owned (buffered + in flight) minus the one leaving this cycle must be < 2.
  assign occupancy   = 3'(count_q) + 3'(inflight_q);
  assign credit_ok   = occupancy < (3'd2 + 3'(pop));
  assign issue       = (state_q == StRun) && !abort_i && (issued_q < num_rows_q) && credit_ok;
  assign last_pop    = (state_q == StDrain) && pop && (accepted_q == num_rows_q - countWidth'(1));
  assign flush       = abort_i && (state_q != StIdle);

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    stride_d        = stride_q;
    num_rows_d      = num_rows_q;
    issued_d        = issued_q;
    accepted_d      = pop ? accepted_q + countWidth'(1) : accepted_q;
    inflight_d      = issue;
    inflight_last_d = issue && (issued_q == num_rows_q - countWidth'(1));
    done_d          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (num_rows_i != '0) begin
            addr_d     = base_addr_i;
            stride_d   = stride_i;
            num_rows_d = num_rows_i;
            issued_d   = '0;
            accepted_d = '0;
            state_d    = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (issue) begin
          addr_d   = addr_q + stride_q;
          issued_d = issued_q + countWidth'(1);
          if (issued_q + countWidth'(1) == num_rows_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (last_pop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d         = StIdle;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      done_d          = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      stride_q        <= '0;
      num_rows_q      <= '0;
      issued_q        <= '0;
      accepted_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      stride_q        <= stride_d;
      num_rows_q      <= num_rows_d;
      issued_q        <= issued_d;
      accepted_q      <= accepted_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  // Output FIFO. The push is the unconditional capture of last cycle's read.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= rd_data_i;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(inflight_q) - 2'(pop);
    end
  end

  assign busy_o     = (state_q != StIdle);
  // An abort in the final-pop cycle already yields the registered pulse; avoid a second one.
  assign done_o     = done_q || (last_pop && !abort_i);
  assign rd_en_o    = issue;
  assign rd_addr_o  = issue ? addr_q : '0;
  assign row_data_o = fifo_data_q[rd_ptr_q];
  assign row_last_o = row_valid_o && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_ram_row_streamer.sv
module tb_ram_row_streamer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i, abort_i, row_ready_i;
  logic [31:0]  base_addr_i, stride_i;
  logic [15:0]  num_rows_i;
  logic         busy_o, done_o, rd_en_o, row_valid_o, row_last_o;
  logic [31:0]  rd_addr_o;
  logic [255:0] rd_data_i, row_data_o;

  int n_checks = 0;
  int n_pass   = 0;

  ram_row_streamer #(
    .addrWidth (32),
    .dataSize  (8),
    .rowWidth  (256),
    .countWidth(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .stride_i   (stride_i),
    .num_rows_i (num_rows_i),
    .abort_i    (abort_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rd_en_o    (rd_en_o),
    .rd_addr_o  (rd_addr_o),
    .rd_data_i  (rd_data_i),
    .row_data_o (row_data_o),
    .row_valid_o(row_valid_o),
    .row_ready_i(row_ready_i),
    .row_last_o (row_last_o)
  );

  always #5 clk = ~clk;

  // Distinct row contents per address.
  function automatic logic [255:0] row_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'h1234_5678, a + 32'd7, {4{a ^ 32'hDEAD_BEEF}}};
  endfunction

  // RAM model: one-cycle read latency.
  always @(posedge clk) rd_data_i <= rd_en_o ? row_of(rd_addr_o) : '0;

  function automatic logic [255:0] ctl(input logic busy, done, rden, valid, last,
                                       input logic [31:0] addr);
    return 256'({busy, done, rden, valid, last, addr});
  endfunction

  function automatic logic [255:0] ctl_now();
    return ctl(busy_o, done_o, rd_en_o, row_valid_o, row_last_o, rd_addr_o);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        start, ready, abort;
    logic        busy, done, rd_en;
    logic [31:0] addr;
    logic        valid, last;
    logic [31:0] data_addr;
  } vec_t;

  vec_t burst[8];

  // base 0, stride 32, 4 rows, ready high; optional ignored start in cycle 2.
  task automatic run_burst(input string tag, input bit busy_start);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start_i     = burst[k].start || (busy_start && k == 2);
      base_addr_i = (busy_start && k == 2) ? 32'h4000 : 32'h0;
      stride_i    = (busy_start && k == 2) ? 32'd64 : 32'd32;
      num_rows_i  = (busy_start && k == 2) ? 16'd2 : 16'd4;
      row_ready_i = burst[k].ready;
      abort_i     = burst[k].abort;
      #1;
      check($sformatf("%s c%0d ctl", tag, k), ctl_now(),
            ctl(burst[k].busy, burst[k].done, burst[k].rd_en, burst[k].valid, burst[k].last,
                burst[k].addr));
      if (burst[k].valid)
        check($sformatf("%s c%0d data", tag, k), row_data_o, row_of(burst[k].data_addr));
    end
    start_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // start ready abort | busy done rd_en addr | valid last data_addr
    burst[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0};
    burst[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0,  1'b0, 1'b0, 32'd0};
    burst[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd32, 1'b0, 1'b0, 32'd0};
    burst[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd64, 1'b1, 1'b0, 32'd0};
    burst[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd96, 1'b1, 1'b0, 32'd32};
    burst[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 32'd64};
    burst[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd96};
    burst[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0};

    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; row_ready_i = 1'b0;
    base_addr_i = '0; stride_i = '0; num_rows_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset ctl", ctl_now(), '0);
    check("reset data", row_data_o, '0);
    @(negedge clk);
    rst = 1'b0;

    run_burst("burst", 1'b0);

    // Zero rows: done one cycle later, no reads.
    @(negedge clk);
    start_i = 1'b1; base_addr_i = 32'h80; stride_i = 32'd32; num_rows_i = 16'd0;
    #1;
    check("zero c0 ctl", ctl_now(), '0);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check("zero c1 ctl", ctl_now(), ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    #1;
    check("zero c2 ctl", ctl_now(), '0);

    run_burst("busystart", 1'b1);

    // Stride with address wrap.
    begin
      logic [31:0] exp_addr [3];
      exp_addr[0] = 32'hFFFF_FFE0; exp_addr[1] = 32'h0000_0020; exp_addr[2] = 32'h0000_0060;
      @(negedge clk);
      start_i = 1'b1; base_addr_i = 32'hFFFF_FFE0; stride_i = 32'h40; num_rows_i = 16'd3;
      row_ready_i = 1'b1;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check($sformatf("wrap c%0d rd", c), {rd_en_o, rd_addr_o}, {1'b1, exp_addr[c-1]});
      end
      check("wrap c3 data", row_data_o, row_of(exp_addr[0]));
      @(negedge clk);
      @(negedge clk);
      #1;
      check("wrap c5 ctl", ctl_now(), ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0));
      check("wrap c5 data", row_data_o, row_of(exp_addr[2]));
      @(negedge clk);
      #1;
      check("wrap c6 ctl", ctl_now(), '0);
    end

    // Backpressure: ready pattern 1,0,0,1 repeating, scoreboarded against the RAM model.
    begin
      int issued_n = 0, popped_n = 0, done_n = 0, c = 0;
      bit fin = 1'b0;
      while (!fin && c < 200) begin
        @(negedge clk);
        start_i     = (c == 0);
        base_addr_i = 32'h100; stride_i = 32'h20; num_rows_i = 16'd6;
        row_ready_i = (c % 4 == 0) || (c % 4 == 3);
        #1;
        if (rd_en_o) begin
          check($sformatf("bp addr %0d", issued_n), rd_addr_o, 32'h100 + 32'(issued_n) * 32'h20);
          issued_n++;
        end
        if (row_valid_o && row_ready_i) begin
          check($sformatf("bp data %0d", popped_n), row_data_o,
                row_of(32'h100 + 32'(popped_n) * 32'h20));
          check($sformatf("bp last %0d", popped_n), row_last_o, (popped_n == 5));
          popped_n++;
        end
        check($sformatf("bp occupancy c%0d", c), (issued_n - popped_n) <= 2, 1'b1);
        if (done_o) begin
          done_n++;
          fin = 1'b1;
          check("bp done with last pop", popped_n, 6);
        end
        c++;
      end
      start_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        #1;
        if (done_o) done_n++;
        if (rd_en_o) issued_n++;
      end
      check("bp done count", done_n, 1);
      check("bp issued total", issued_n, 6);
      check("bp popped total", popped_n, 6);
    end

    // Abort with ready low: FIFO fills, reads stop, abort flushes.
    @(negedge clk);
    start_i = 1'b1; base_addr_i = 32'h0; stride_i = 32'd32; num_rows_i = 16'd8;
    row_ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check("abort c1 ctl", ctl_now(), ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    #1;
    check("abort c2 ctl", ctl_now(), ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd32));
    @(negedge clk);
    #1;
    check("abort c3 ctl", ctl_now(), ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0));
    @(negedge clk);
    abort_i = 1'b1;
    #1;
    check("abort c4 ctl", ctl_now(), ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0));
    check("abort c4 data", row_data_o, row_of(32'd0));
    @(negedge clk);
    abort_i = 1'b0;
    #1;
    check("abort c5 ctl", ctl_now(), ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    #1;
    check("abort c6 ctl", ctl_now(), '0);

    run_burst("postabort", 1'b0);

    // Reset mid-transfer.
    @(negedge clk);
    start_i = 1'b1; base_addr_i = 32'h0; stride_i = 32'd32; num_rows_i = 16'd8;
    row_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid c4 ctl", ctl_now(), '0);
    check("rstmid c4 data", row_data_o, '0);
    @(negedge clk);
    #1;
    check("rstmid c5 ctl", ctl_now(), '0);

    run_burst("postreset", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
